instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/if_pkg.sv | 24 ++
 rtl/fetch_buffer.sv | 58 +++++
 rtl/instruction_fetch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and sizing for the instruction fetch unit.
package if_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DROP  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} pairs between fetch and decode.
module fetch_buffer
    import if_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               not_empty
);

    fetch_entry_t     mem [BUF_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_nxt;

    // A push into a full buffer is only accepted when a pop frees a slot.
    always_comb begin
        do_pop    = pop && (count != '0);
        do_push   = push && ((count != CNT_W'(BUF_DEPTH)) || do_pop);
        count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            not_empty <= 1'b0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else if (flush) begin
            count     <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            not_empty <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count     <= count_nxt;
            not_empty <= (count_nxt != '0);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory requests feeding a 2-entry buffer.
// Optional FETCH_MISALIGN_TRAP_EN traps misaligned fetch PCs into FAULT.
module instruction_fetch
    import if_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_now,
    output logic            pc_advance,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault
`endif
);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic             load_addr;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] post_cnt;
    logic [XLEN-1:0]  fetch_pc;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // The program counter moves to pc_now+4 on the same edge as a push, so
    // a back-to-back request must capture that address rather than pc_now.
    always_comb begin
        push       = (state == REQ) && imem_ack && !redirect;
        pop        = instr_valid && instr_ready && !redirect;
        post_cnt   = count + CNT_W'(push) - CNT_W'(pop);
        fetch_pc   = push ? (pc_now + XLEN'(4)) : pc_now;
        push_entry = '{pc: imem_addr, instr: imem_rdata};
    end

    assign pc_advance = push;

    always_comb begin
        state_nxt = state;
        load_addr = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && (count <= CNT_W'(1))) begin
                    state_nxt = REQ;
                    load_addr = 1'b1;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (!redirect && (post_cnt == CNT_W'(BUF_DEPTH))) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = REQ;
                        load_addr = 1'b1;
                    end
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_nxt = REQ;
                    load_addr = 1'b1;
                end
            end
            FAULT: begin
                if (redirect) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (load_addr && (fetch_pc[1:0] != 2'b00)) begin
            state_nxt = FAULT;
            load_addr = 1'b0;
        end
`endif
    end

    // DROP keeps the request asserted so the abandoned access still completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state    <= state_nxt;
            imem_req <= (state_nxt == REQ) || (state_nxt == DROP);
            if (load_addr) begin
                imem_addr <= word_align(fetch_pc);
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_fault <= 1'b0;
        end else begin
            fetch_fault <= (state_nxt == FAULT);
        end
    end
`endif

    fetch_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .not_empty (instr_valid)
    );

    assign instr    = head.instr;
    assign instr_pc = head.pc;

endmodule
